// File: rtl/mult_step_sequencer_if.sv
// Control/handshake bundle between the shift-add multiplier datapath and its step sequencer.
interface mult_step_sequencer_if #(
    parameter int unsigned CW = 4
);
    logic          Run;
    logic          Pause;
    logic          M_bit;
    logic          Clear_A;
    logic          Add_En;
    logic          Sub_En;
    logic          Shift_En;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Step;

    modport master (
        output Run, Pause, M_bit,
        input  Clear_A, Add_En, Sub_En, Shift_En, Busy, Done, Step
    );

    modport slave (
        input  Run, Pause, M_bit,
        output Clear_A, Add_En, Sub_En, Shift_En, Busy, Done, Step
    );
endinterface

// File: rtl/mult_step_sequencer.sv
// Shift-add multiplier sequencer: one clear cycle, then N_STEPS ADD/SHIFT pairs,
// with the final add turned into a subtract for two's-complement correction.
module mult_step_sequencer #(
    parameter int unsigned N_STEPS    = 8,
    parameter int unsigned CW         = 4,
    parameter int unsigned AUTO_REARM = 0
) (
    input logic                   Clk,
    input logic                   Reset,
    mult_step_sequencer_if.slave  bus
);
    localparam logic [CW-1:0] LAST_STEP = CW'(N_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] step, step_nxt;
    logic          done;
    logic          clear_a, add_en, sub_en, shift_en, busy;
    logic          last;

    assign last = (step == LAST_STEP);

    // State, step index and the registered completion pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            step  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            done  <= (state_nxt == S_HOLD) && (state != S_HOLD);
        end
    end

    // Next state, step update and combinational datapath strobes.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        clear_a   = 1'b0;
        add_en    = 1'b0;
        sub_en    = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.Run) begin
                    state_nxt = S_CLEAR;
                    step_nxt  = '0;
                end
            end
            S_CLEAR: begin
                clear_a   = 1'b1;
                busy      = 1'b1;
                step_nxt  = '0;
                state_nxt = S_ADD;
            end
            S_ADD: begin
                busy = 1'b1;
                if (!bus.Pause) begin
                    add_en    = bus.M_bit & ~last;
                    sub_en    = bus.M_bit & last;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (!bus.Pause) begin
                    shift_en = 1'b1;
                    if (last) begin
                        state_nxt = S_HOLD;
                    end else begin
                        step_nxt  = step + CW'(1);
                        state_nxt = S_ADD;
                    end
                end
            end
            S_HOLD: begin
                // Re-arm either unconditionally or once the requester releases Run.
                if ((AUTO_REARM != 0) || !bus.Run) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.Clear_A  = clear_a;
    assign bus.Add_En   = add_en;
    assign bus.Sub_En   = sub_en;
    assign bus.Shift_En = shift_en;
    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.Step     = step;
endmodule

// File: tb/tb_mult_step_sequencer.sv
// Directed bench for mult_step_sequencer: one instance per re-arm mode, shared clock/reset.
module tb_mult_step_sequencer;
    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic Clk;
    logic Reset;
    int   vectors;
    int   miscompares;

    mult_step_sequencer_if #(.CW(CW)) b0 ();
    mult_step_sequencer_if #(.CW(CW)) b1 ();

    mult_step_sequencer #(.N_STEPS(N), .CW(CW), .AUTO_REARM(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .bus(b0)
    );
    mult_step_sequencer #(.N_STEPS(N), .CW(CW), .AUTO_REARM(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .bus(b1)
    );

    // {Clear_A, Add_En, Sub_En, Shift_En, Busy, Done, Step}
    logic [9:0] v0, v1;
    assign v0 = {b0.Clear_A, b0.Add_En, b0.Sub_En, b0.Shift_En, b0.Busy, b0.Done, b0.Step};
    assign v1 = {b1.Clear_A, b1.Add_En, b1.Sub_En, b1.Shift_En, b1.Busy, b1.Done, b1.Step};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected output vector for cycle k after Run was sampled (k=1 is CLEAR).
    // A pause window [ps, ps+pl) placed on an ADD cycle freezes that step.
    function automatic logic [9:0] exp_vec(input int k, input logic m, input int ps, input int pl);
        int e;
        int s;
        if (ps > 0 && k >= ps && k < ps + pl) begin
            s = (ps - 2) / 2;
            return {4'b0000, 1'b1, 1'b0, 4'(s)};
        end
        e = (ps > 0 && k >= ps + pl) ? k - pl : k;
        if (e <= 0) return 10'd0;
        if (e == 1) return 10'b1000100000;
        if (e <= 2 * N + 1) begin
            s = (e - 2) / 2;
            if (e % 2 == 0)
                return {1'b0, m && (s != N - 1), m && (s == N - 1), 1'b0, 1'b1, 1'b0, 4'(s)};
            return {3'b000, 1'b1, 1'b1, 1'b0, 4'(s)};
        end
        if (e == 2 * N + 2) return {5'b00000, 1'b1, 4'(N - 1)};
        return {6'b000000, 4'(N - 1)};
    endfunction

    // Full operation on dut0 with optional pause window and Run toggling while busy.
    task automatic run_seq(input string tag, input logic m, input int ps, input int pl, input bit toggle);
        int n_add, n_sub, n_shift, n_busy, n_done, n_clear;
        n_add = 0; n_sub = 0; n_shift = 0; n_busy = 0; n_done = 0; n_clear = 0;
        b0.M_bit = m;
        b0.Run   = 1'b1;
        tick();
        for (int k = 1; k <= 2 * int'(N) + 3 + pl; k++) begin
            b0.Pause = (ps > 0 && k >= ps && k < ps + pl);
            b0.Run   = toggle ? ((k < 2 * int'(N) + 1) ? k[0] : 1'b0) : 1'b0;
            #1;
            chk(tag, v0, exp_vec(k, m, ps, pl));
            n_clear += int'(v0[9]);
            n_add   += int'(v0[8]);
            n_sub   += int'(v0[7]);
            n_shift += int'(v0[6]);
            n_busy  += int'(v0[5]);
            n_done  += int'(v0[4]);
            tick();
        end
        b0.Pause = 1'b0;
        chk({tag, "_nclear"}, 10'(n_clear), 10'd1);
        chk({tag, "_nadd"},   10'(n_add),   m ? 10'd7 : 10'd0);
        chk({tag, "_nsub"},   10'(n_sub),   m ? 10'd1 : 10'd0);
        chk({tag, "_nshift"}, 10'(n_shift), 10'd8);
        chk({tag, "_nbusy"},  10'(n_busy),  10'(17 + pl));
        chk({tag, "_ndone"},  10'(n_done),  10'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset    = 1'b1;
        b0.Run   = 1'b1; b0.Pause = 1'b0; b0.M_bit = 1'b0;
        b1.Run   = 1'b0; b1.Pause = 1'b0; b1.M_bit = 1'b1;

        // 1: reset with Run held, then release
        tick(); tick();
        chk("reset_dut0", v0, 10'd0);
        chk("reset_dut1", v1, 10'd0);
        Reset = 1'b0;
        tick();
        chk("post_reset_clear", v0, exp_vec(1, 1'b0, 0, 0));
        b0.Run = 1'b0;
        tick();
        chk("post_reset_add", v0, exp_vec(2, 1'b0, 0, 0));
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("reset_mid_add", v0, 10'd0);

        // 2: M_bit=1 full operation
        run_seq("m1", 1'b1, 0, 0, 1'b0);
        // 3: M_bit=0 full operation
        run_seq("m0", 1'b0, 0, 0, 1'b0);
        // 4: pause for three cycles on step 3 ADD (cycle 8)
        run_seq("pause", 1'b1, 8, 3, 1'b0);

        // 5: Run held high on both re-arm modes
        Reset = 1'b1; tick(); Reset = 1'b0;
        b0.M_bit = 1'b1;
        b0.Run = 1'b1; b1.Run = 1'b1;
        tick();
        for (int k = 1; k <= 22; k++) begin
            chk("hold_dut0", v0, exp_vec(k, 1'b1, 0, 0));
            if (k <= 18)      chk("rearm_dut1", v1, exp_vec(k, 1'b1, 0, 0));
            else if (k == 19) chk("rearm_idle", v1, 10'd7);
            else              chk("rearm_again", v1, exp_vec(k - 19, 1'b1, 0, 0));
            tick();
        end
        b0.Run = 1'b0; b1.Run = 1'b0;
        tick();
        chk("hold_release", v0, 10'd7);
        b0.Run = 1'b1;
        tick();
        chk("idle_restart", v0, exp_vec(1, 1'b1, 0, 0));
        b0.Run = 1'b0;
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("reset_both0", v0, 10'd0);
        chk("reset_both1", v1, 10'd0);

        // 6a: reset during step 5 SHIFT (cycle 13)
        b0.Run = 1'b1;
        tick();
        b0.Run = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            chk("pre_abort", v0, exp_vec(k, 1'b1, 0, 0));
            if (k < 13) tick();
        end
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("abort_idle", v0, 10'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_quiet", v0, 10'd0);
        end

        // 6b: Run toggling while busy has no effect
        run_seq("toggle", 1'b1, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
